// File: rtl/keypad_scanner_if.sv
// Keypad-side bundle for keypad_scanner: row sense in, column drive and key
// report out. The master is the scanner; the slave is the keypad/decoder side.
interface keypad_scanner_if;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [3:0] button;
  logic       en;

  modport master (input rows, output cols, output button, output en);
  modport slave  (output rows, input cols, input button, input en);
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner with press/release debounce and a one-cycle
// strobe per accepted key. Define KEYPAD_SYNC_EN to add a 2-flop row synchronizer.
module keypad_scanner #(
  parameter int SCAN_DIV        = 2048,
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic                int_osc,
  input  logic                reset,
  keypad_scanner_if.master    kp
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] DEB_LAST   = BW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {ST_SCAN, ST_DEBOUNCE, ST_HELD, ST_RELEASE} state_e;

  state_e        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [1:0]    row_q, row_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [BW-1:0] deb_q, deb_d;
  logic [3:0]    button_q, button_d;
  logic          en_q, en_d;
  logic [3:0]    rows_s;
  logic          row_low;

`ifdef KEYPAD_SYNC_EN
  logic [3:0] sync1_q, sync2_q;

  // Flops reset to 1 so that a reset never looks like a key press.
  always_ff @(posedge int_osc or negedge reset) begin
    if (!reset) begin
      sync1_q <= 4'hF;
      sync2_q <= 4'hF;
    end else begin
      sync1_q <= kp.rows;
      sync2_q <= sync1_q;
    end
  end

  assign rows_s = sync2_q;
`else
  assign rows_s = kp.rows;
`endif

  function automatic logic [1:0] lowest_row(input logic [3:0] r);
    if      (!r[0]) return 2'd0;
    else if (!r[1]) return 2'd1;
    else if (!r[2]) return 2'd2;
    else            return 2'd3;
  endfunction

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: return 4'h1;  4'h1: return 4'h2;  4'h2: return 4'h3;  4'h3: return 4'hA;
      4'h4: return 4'h4;  4'h5: return 4'h5;  4'h6: return 4'h6;  4'h7: return 4'hB;
      4'h8: return 4'h7;  4'h9: return 4'h8;  4'hA: return 4'h9;  4'hB: return 4'hC;
      4'hC: return 4'hE;  4'hD: return 4'h0;  4'hE: return 4'hF;  default: return 4'hD;
    endcase
  endfunction

  // Once a key is latched only its own row matters; other rows are ignored.
  assign row_low = !rows_s[row_q];

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    state_d  = state_q;
    idx_d    = idx_q;
    row_d    = row_q;
    dwell_d  = dwell_q;
    deb_d    = deb_q;
    button_d = button_q;
    en_d     = 1'b0;

    case (state_q)
      ST_SCAN: begin
        if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          if (rows_s != 4'hF) begin
            row_d   = lowest_row(rows_s);
            deb_d   = '0;
            state_d = ST_DEBOUNCE;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end

      ST_DEBOUNCE: begin
        if (!row_low) begin
          state_d = ST_SCAN;
          idx_d   = idx_q + 2'd1;
          dwell_d = '0;
        end else if (deb_q == DEB_LAST) begin
          button_d = key_code(row_q, idx_q);
          en_d     = 1'b1;
          state_d  = ST_HELD;
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end

      ST_HELD: begin
        if (!row_low) begin
          deb_d   = '0;
          state_d = ST_RELEASE;
        end
      end

      ST_RELEASE: begin
        if (row_low) begin
          deb_d = '0;
        end else if (deb_q == DEB_LAST) begin
          state_d = ST_SCAN;
          idx_d   = idx_q + 2'd1;
          dwell_d = '0;
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end

      default: state_d = ST_SCAN;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every flop samples
  // the pre-edge value of the others.
  always_ff @(posedge int_osc or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_SCAN;
      idx_q    <= 2'd0;
      row_q    <= 2'd0;
      dwell_q  <= '0;
      deb_q    <= '0;
      button_q <= 4'h0;
      en_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      row_q    <= row_d;
      dwell_q  <= dwell_d;
      deb_q    <= deb_d;
      button_q <= button_d;
      en_q     <= en_d;
    end
  end

  assign kp.cols   = ~(4'b0001 << idx_q);
  assign kp.button = button_q;
  assign kp.en     = en_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a behavioural 4x4 keypad model closes
// the loop from cols back to rows; expected codes and latencies are hand-derived.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 8;
`ifdef KEYPAD_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic        int_osc = 1'b0;
  logic        reset   = 1'b0;
  logic [15:0] pressed = '0;
  logic [3:0]  rows_model;

  int n_checks   = 0;
  int n_pass     = 0;
  int en_cnt     = 0;
  int en_double  = 0;
  logic en_prev  = 1'b0;

  keypad_scanner_if kp();

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CYCLES(DEB)) dut (
    .int_osc (int_osc),
    .reset   (reset),
    .kp      (kp)
  );

  always #5 int_osc = ~int_osc;

  // A pressed key shorts its row to its column whenever that column is driven low.
  always_comb begin
    rows_model = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !kp.cols[c]) rows_model[r] = 1'b0;
  end
  assign kp.rows = rows_model;

  always @(negedge int_osc) begin
    if (kp.en) en_cnt <= en_cnt + 1;
    if (kp.en && en_prev) en_double <= en_double + 1;
    en_prev <= kp.en;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge int_osc);
      #1;
    end
  endtask

  function automatic logic [3:0] col_drive(input int c);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << c);
  endfunction

  task automatic press(input int r, input int c);
    pressed[r*4+c] = 1'b1;
  endtask

  task automatic lift(input int r, input int c);
    pressed[r*4+c] = 1'b0;
  endtask

  task automatic wait_en(input string tag, input int budget);
    int start;
    int n;
    start = en_cnt;
    n = 0;
    while (en_cnt == start && n < budget) begin
      tick();
      n++;
    end
    check(tag, en_cnt - start, 1);
  endtask

  task automatic wait_col_start(input string tag, input int c, input int budget);
    logic [3:0] prev;
    int n;
    bit found;
    n = 0;
    found = 0;
    while (!found && n < budget) begin
      prev = kp.cols;
      tick();
      n++;
      if (kp.cols == col_drive(c) && prev != col_drive(c)) found = 1;
    end
    check(tag, found, 1);
  endtask

  task automatic wait_cols_change(output int n, input int budget);
    logic [3:0] old;
    old = kp.cols;
    n = 0;
    while (kp.cols == old && n < budget) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int base;
    int n;

    // Reset state
    tick(3);
    check("rst_cols", kp.cols, 4'b1110);
    check("rst_button", kp.button, 4'h0);
    check("rst_en", kp.en, 1'b0);
    reset = 1'b1;

    // Idle scan: each column low for SCAN_DIV cycles, wrapping 3 -> 0
    for (int k = 0; k <= 16; k++) begin
      check($sformatf("scan_cols_%0d", k), kp.cols, col_drive((k / SCAN_DIV) % 4));
      if (k != 16) tick();
    end
    check("scan_no_en", en_cnt, 0);
    check("scan_button", kp.button, 4'h0);

    // Single steady press of (r1,c2) -> '6', clean release resumes at c3
    base = en_cnt;
    press(1, 2);
    wait_en("k6_en", 60);
    check("k6_button", kp.button, 4'h6);
    tick(25);
    check("k6_one_en", en_cnt - base, 1);
    lift(1, 2);
    wait_cols_change(n, 40);
    check("k6_release_len", n, 9 + SYNC_LAT);
    check("k6_next_col", kp.cols, col_drive(3));
    check("k6_no_release_en", en_cnt - base, 1);

    // Bounce during DEBOUNCE on (r3,c1): abort to SCAN, then a stable press -> '0'
    wait_col_start("k0_col1", 1, 40);
    base = en_cnt;
    press(3, 1);
    tick(6);
    lift(3, 1);
    tick(3);
    press(3, 1);
    tick(1);
    check("k0_bounce_col", kp.cols, col_drive(2));
    tick(4);
    check("k0_bounce_no_en", en_cnt - base, 0);
    wait_en("k0_en", 60);
    check("k0_button", kp.button, 4'h0);
    tick(15);
    check("k0_one_en", en_cnt - base, 1);
    lift(3, 1);
    tick(25);
    check("k0_no_release_en", en_cnt - base, 1);

    // Second key pressed while HELD is never reported
    base = en_cnt;
    press(0, 0);
    wait_en("k1_en", 60);
    check("k1_button", kp.button, 4'h1);
    press(2, 0);
    tick(20);
    check("k1_second_ignored", en_cnt - base, 1);
    check("k1_button_kept", kp.button, 4'h1);
    lift(2, 0);
    tick(10);
    lift(0, 0);
    tick(25);
    check("k1_no_release_en", en_cnt - base, 1);

    // Two rows low at detection: lowest row (r1,c3) -> 'B'
    base = en_cnt;
    press(1, 3);
    press(2, 3);
    wait_en("kb_en", 60);
    check("kb_button", kp.button, 4'hB);
    tick(5);
    lift(1, 3);
    lift(2, 3);
    tick(25);
    check("kb_one_en", en_cnt - base, 1);

    // Reset mid-DEBOUNCE on (r3,c3), key still held afterwards -> 'D'
    wait_col_start("kd_col3", 3, 40);
    press(3, 3);
    base = en_cnt;
    tick(7);
    reset = 1'b0;
    #1;
    check("kd_rst_cols", kp.cols, 4'b1110);
    check("kd_rst_button", kp.button, 4'h0);
    check("kd_rst_en", kp.en, 1'b0);
    tick(3);
    check("kd_rst_no_en", en_cnt - base, 0);
    reset = 1'b1;
    wait_en("kd_en", 60);
    check("kd_button", kp.button, 4'hD);
    tick(10);
    lift(3, 3);
    tick(25);
    check("kd_one_en", en_cnt - base, 1);

    // Release bounce: one low cycle at count 5 restarts the release count
    base = en_cnt;
    press(2, 2);
    wait_en("k9_en", 60);
    check("k9_button", kp.button, 4'h9);
    tick(5);
    lift(2, 2);
    tick(6);
    press(2, 2);
    tick(1);
    lift(2, 2);
    wait_cols_change(n, 40);
    check("k9_release_len", n, 8 + SYNC_LAT);
    check("k9_next_col", kp.cols, col_drive(3));
    check("k9_one_en", en_cnt - base, 1);

    check("en_never_back_to_back", en_double, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
